button_debounce: RTL and testbench

- Input-side counterpart of the LED pulse-stretching delay block: that block turns a one-cycle event into a timed output level; this block turns a noisy, asynchronous button level into clean single-cycle events.
- Sits between the board or virtual button input and the rest of the button-LED virtual interface logic.
- Synchronises the raw input, requires STABLE_CLKS consecutive equal samples before accepting a change, then emits a debounced level plus press and release pulses.

---
 rtl/button_if_pkg.sv | 14 +
 rtl/sync_2ff.sv | 22 ++
 rtl/button_debounce.sv | 147 ++++++++++++++
 tb/tb_button_debounce.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_if_pkg.sv
// Shared types and defaults for the button / LED virtual interface logic.
package button_if_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_e;

  localparam int DEBOUNCE_CLKS_DEFAULT = 4;
  localparam int LONG_CLKS_DEFAULT     = 1000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // Shift the asynchronous level through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Button debouncer: synchronises a raw button level, qualifies changes over
// STABLE_CLKS consecutive samples and emits a clean level plus press/release
// pulses. Defining LONG_PRESS_EN adds a one-shot long-press pulse fired
// LONG_CLKS cycles into a hold; otherwise long_pulse is constant 0.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | button accepted as released, level 0
// DEB_PRESS   | seeing 1s while released, counting toward acceptance
// HELD        | button accepted as pressed, level 1
// DEB_RELEASE | seeing 0s while pressed, counting toward acceptance
module button_debounce
  import button_if_pkg::*;
#(
  parameter int STABLE_CLKS = DEBOUNCE_CLKS_DEFAULT,
  parameter int LONG_CLKS   = LONG_CLKS_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw_button,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CW = $clog2(STABLE_CLKS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CLKS - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic          s;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d, press_d, release_d;

  sync_2ff u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (raw_button),
    .q     (s)
  );

  // State, qualification counter and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      button_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      button_level  <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  // Next state: any reversal during qualification falls back to the stable state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = button_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = DEB_PRESS;
          cnt_d   = CW'(1);
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_d = DEB_RELEASE;
          cnt_d   = CW'(1);
        end
      end
      DEB_RELEASE: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CLKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CLKS);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_d;

  // Hold counter survives DEB_RELEASE so a bounce back to HELD cannot re-arm it.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_q == IDLE || press_d) begin
      hold_d = '0;
    end else if (state_q == HELD && hold_q != HOLD_LAST) begin
      hold_d = hold_q + HW'(1);
      long_d = (hold_d == HOLD_LAST);
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_q     <= '0;
      long_pulse <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      long_pulse <= long_d;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with a sample-history reference model.
module tb_button_debounce;

  localparam int STABLE = 4;
  localparam int LONG   = 10;
`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic raw = 1'b0;
  logic button_level, press_pulse, release_pulse, long_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int n_edge = 0;

  button_debounce #(.STABLE_CLKS(STABLE), .LONG_CLKS(LONG)) dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .raw_button    (raw),
    .button_level  (button_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) n_edge++;

  // Reference model: the synchronised sample is raw delayed by two edges; a
  // level change is accepted once STABLE consecutive samples disagree with
  // the accepted level. Long press counts edges spent settled at level 1.
  logic m_s1 = 0, m_s = 0, m_lvl = 0, m_press = 0, m_rel = 0, m_long = 0;
  int   m_run = 0, m_hold = 0;
  logic m_cur;
  bit   m_settled;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s = 0; m_lvl = 0; m_press = 0; m_rel = 0; m_long = 0;
      m_run = 0; m_hold = 0;
    end else begin
      m_cur     = m_s;
      m_settled = m_lvl && (m_run == 0);
      m_s  = m_s1;
      m_s1 = raw;
      m_press = 0; m_rel = 0; m_long = 0;
      if (m_settled && m_hold < LONG) begin
        m_hold++;
        if (m_hold == LONG) m_long = LONG_EN;
      end
      if (m_cur != m_lvl) begin
        m_run++;
        if (m_run == STABLE) begin
          m_lvl = m_cur;
          m_run = 0;
          if (m_cur) begin
            m_press = 1;
            m_hold  = 0;
          end else begin
            m_rel = 1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    check("level",   int'(button_level),  int'(m_lvl));
    check("press",   int'(press_pulse),   int'(m_press));
    check("release", int'(release_pulse), int'(m_rel));
    check("long",    int'(long_pulse),    int'(m_long));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 press, 1 release, 2 long. Returns edge index the pulse followed.
  task automatic wait_pulse(input int which, input int bound, output int e, output bit found);
    logic p;
    found = 0;
    e = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      p = (which == 0) ? press_pulse : (which == 1) ? release_pulse : long_pulse;
      if (p) begin
        found = 1;
        e = n_edge;
        break;
      end
    end
  endtask

  initial begin
    int  e0, e, e_long, n_press, n_long, n_lvl;
    bit  f;
    logic pat [9];

    // Reset state
    #1 rst_n = 0;
    #11;
    check("rst_level", int'(button_level), 0);
    check("rst_press", int'(press_pulse), 0);
    check("rst_release", int'(release_pulse), 0);
    check("rst_long", int'(long_pulse), 0);
    cyc(3);
    rst_n = 1;
    cyc(3);

    // Clean press: level rises after edge k+5
    raw = 1;
    e0 = n_edge;
    wait_pulse(0, 20, e, f);
    check("press_found", int'(f), 1);
    check("press_latency", e - (e0 + 1), 5);
    check("press_level", int'(button_level), 1);
    @(negedge clk);
    check("press_one_cycle", int'(press_pulse), 0);

    // Hold 30 cycles: long pulse only when enabled, 10 cycles after press
    n_long = 0;
    e_long = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (long_pulse) begin
        n_long++;
        if (e_long < 0) e_long = n_edge;
      end
    end
    check("long_count", n_long, LONG_EN ? 1 : 0);
    if (LONG_EN) check("long_latency", e_long - e, 10);

    // Release
    raw = 0;
    e0 = n_edge;
    wait_pulse(1, 20, e, f);
    check("release_found", int'(f), 1);
    check("release_latency", e - (e0 + 1), 5);
    check("release_level", int'(button_level), 0);

    // Two-cycle glitch is rejected
    cyc(5);
    raw = 1;
    cyc(2);
    raw = 0;
    n_press = 0;
    n_lvl = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (press_pulse) n_press++;
      if (button_level) n_lvl++;
    end
    check("glitch_press", n_press, 0);
    check("glitch_level", n_lvl, 0);

    // Bounce 1,0,1,1,0,1,1,1,1: one press, 11 edges after the first sample
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    e0 = n_edge;
    n_press = 0;
    e = -1;
    for (int i = 0; i < 24; i++) begin
      raw = (i < 9) ? pat[i] : 1'b1;
      @(negedge clk);
      if (press_pulse) begin
        n_press++;
        if (e < 0) e = n_edge;
      end
    end
    check("bounce_count", n_press, 1);
    check("bounce_latency", e - e0, 11);
    raw = 0;
    cyc(10);

    // Reset in HELD: asynchronous drop, no release, re-press after 6 edges
    raw = 1;
    wait_pulse(0, 20, e, f);
    check("held_found", int'(f), 1);
    cyc(3);
    check("held_level", int'(button_level), 1);
    #2 rst_n = 0;
    #1;
    check("async_level", int'(button_level), 0);
    check("async_release", int'(release_pulse), 0);
    @(negedge clk);
    check("reset_no_release", int'(release_pulse), 0);
    rst_n = 1;
    e0 = n_edge;
    wait_pulse(0, 20, e, f);
    check("repress_found", int'(f), 1);
    check("repress_latency", e - e0, 6);
    raw = 0;
    cyc(10);

    // Random runs of levels, occasional reset, checked by the model
    for (int seg = 0; seg < 350; seg++) begin
      raw = ~raw;
      cyc($urandom_range(1, 9));
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end
    end
    raw = 0;
    cyc(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
